// File: rtl/bs_shift_arbiter_pkg.sv
// Shared types and constants for the CAVLC barrel-shifter arbiter.
package bs_shift_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, ACK} bs_arb_state_t;

    localparam int MAX_SHIFT = 16;
    localparam int SHIFT_W   = 5;

endpackage

// File: rtl/bs_shift_arbiter_if.sv
// Bus between the syntax-element decoders, the arbiter and the barrel shifter.
// slave: arbiter view; master: decoder/shifter view.
interface bs_shift_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import bs_shift_pkg::*;

    logic [NUM_REQ-1:0]         ReqValid;
    logic [NUM_REQ*SHIFT_W-1:0] ReqNumShift;
    logic [NUM_REQ-1:0]         Ack;
    logic [15:0]                Window;
    logic                       BarrelShifterReady;
    logic [15:0]                BitstreamShifted;
    logic                       ShiftEn;
    logic [SHIFT_W-1:0]         NumShift;

    modport slave (
        input  ReqValid, ReqNumShift, BarrelShifterReady, BitstreamShifted,
        output Ack, Window, ShiftEn, NumShift
    );

    modport master (
        output ReqValid, ReqNumShift, BarrelShifterReady, BitstreamShifted,
        input  Ack, Window, ShiftEn, NumShift
    );
endinterface

// File: rtl/bs_shift_arbiter_req_select.sv
// Combinational winner pick among pending requesters.
// BS_SHIFT_ARB_RR_EN: round-robin search starting at RrPtr; otherwise
// fixed priority with index 0 highest.
module bs_req_select
    import bs_shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] ReqValid,
`ifdef BS_SHIFT_ARB_RR_EN
    input  logic [IDX_W-1:0]   RrPtr,
`endif
    output logic [NUM_REQ-1:0] WinOneHot,
    output logic [IDX_W-1:0]   WinIdx
);

`ifdef BS_SHIFT_ARB_RR_EN
    // First pending requester at or after RrPtr, wrapping around
    always_comb begin
        logic           found;
        int             j;
        logic [IDX_W-1:0] jIdx;
        WinOneHot = '0;
        WinIdx    = '0;
        found     = 1'b0;
        j         = 0;
        jIdx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(RrPtr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jIdx = IDX_W'(j);
            if (!found && ReqValid[jIdx]) begin
                found           = 1'b1;
                WinOneHot[jIdx] = 1'b1;
                WinIdx          = jIdx;
            end
        end
    end
`else
    // Lowest pending index wins; scanned downwards so the last hit is the lowest
    always_comb begin
        WinOneHot = '0;
        WinIdx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (ReqValid[i]) begin
                WinOneHot    = '0;
                WinOneHot[i] = 1'b1;
                WinIdx       = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/bs_shift_arbiter.sv
// Arbiter sharing the single CAVLC barrel shifter between NUM_REQ decoders.
// One transaction is IDLE (grant) -> SHIFT (ShiftEn strobe) -> ACK (Ack + Window).
// Optional macro BS_SHIFT_ARB_RR_EN selects round-robin instead of fixed priority.
module bs_shift_arbiter
    import bs_shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    bs_shift_arbiter_if.slave bus,
    output logic              Busy,
    output logic              ShiftErr,
    output logic [CNT_W-1:0]  BitCount
);

    localparam int IDX_W = $clog2(NUM_REQ);

    bs_arb_state_t      state, stateNext;
    logic [NUM_REQ-1:0] grant_p0;
    logic [NUM_REQ-1:0] winOneHot;
    logic [IDX_W-1:0]   winIdx;
    logic [SHIFT_W-1:0] reqAmt;
    logic               start;
    logic               shiftEn_p1;
    logic [SHIFT_W-1:0] numShift_p1;
    logic               shiftErrQ;
    logic [CNT_W-1:0]   bitCountQ;

    function automatic logic [SHIFT_W-1:0] clampShift(input logic [SHIFT_W-1:0] amt);
        return (amt > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : amt;
    endfunction

`ifdef BS_SHIFT_ARB_RR_EN
    logic [IDX_W-1:0] rrPtr;

    bs_req_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) uSelect (
        .ReqValid (bus.ReqValid),
        .RrPtr    (rrPtr),
        .WinOneHot(winOneHot),
        .WinIdx   (winIdx)
    );

    // Round-robin pointer moves just past each winner
    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            rrPtr <= '0;
        end else if (start) begin
            rrPtr <= (winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : winIdx + IDX_W'(1);
        end
    end
`else
    bs_req_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) uSelect (
        .ReqValid (bus.ReqValid),
        .WinOneHot(winOneHot),
        .WinIdx   (winIdx)
    );
`endif

    assign start = (state == IDLE) && Enable && bus.BarrelShifterReady && (|bus.ReqValid);

    // Shift amount requested by the current winner
    always_comb begin
        reqAmt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == IDX_W'(i)) reqAmt = bus.ReqNumShift[i*SHIFT_W +: SHIFT_W];
        end
    end

    // State register; Enable low parks the FSM in IDLE
    always_ff @(posedge Clk) begin
        if (Reset || !Enable) state <= IDLE;
        else                  state <= stateNext;
    end

    // Next-state: fixed three-cycle walk once a grant is taken
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = SHIFT;
            SHIFT:   stateNext = ACK;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Stage p0 -> p1: latch grant, shift strobe/amount, error flag, bit counter
    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            grant_p0    <= '0;
            shiftEn_p1  <= 1'b0;
            numShift_p1 <= '0;
            shiftErrQ   <= 1'b0;
            bitCountQ   <= '0;
        end else begin
            shiftEn_p1  <= start;
            numShift_p1 <= start ? clampShift(reqAmt) : '0;
            if (start) begin
                grant_p0 <= winOneHot;
                if (reqAmt > SHIFT_W'(MAX_SHIFT)) shiftErrQ <= 1'b1;
            end
            if (state == SHIFT) bitCountQ <= bitCountQ + CNT_W'(numShift_p1);
        end
    end

    // Enable gates the outputs so an abort takes effect in the same cycle
    assign bus.ShiftEn  = shiftEn_p1 & Enable;
    assign bus.NumShift = numShift_p1 & {SHIFT_W{Enable}};
    assign bus.Ack      = (state == ACK && Enable) ? grant_p0 : '0;
    assign bus.Window   = bus.BitstreamShifted;
    assign Busy         = (state != IDLE) && Enable;
    assign ShiftErr     = shiftErrQ & Enable;
    assign BitCount     = Enable ? bitCountQ : '0;

endmodule

// File: doc/bs_shift_arbiter.md
Name: bs_shift_arbiter

Overview:
- Shares the single CAVLC bitstream barrel shifter between NUM_REQ syntax-element decoders, e.g. coeff_token, level, total_zeros and run_before.
- Each requester asks to consume 0-16 bits. The arbiter grants one requester at a time and drives ShiftEn/NumShift for one cycle.
- It then acknowledges the grantee with the updated 16-bit window.
- It sits between the decoder FSMs and the barrel shifter; it is the only driver of ShiftEn/NumShift.

Parameters:
- NUM_REQ, 4, number of requesters (2-8).
- CNT_W, 32, width of the consumed-bit counter.

Ports:
- Clk  in  1  clock
- Reset  in  1  reset, synchronous, active-high
- Enable  in  1  block enable; low aborts and idles
- BarrelShifterReady  in  1  shifter FIFOs primed
- BitstreamShifted  in  16  current shifter window
- ReqValid  in  NUM_REQ  per-requester request, held until Ack
- ReqNumShift  in  NUM_REQ*5  bits to consume; requester i uses [5i+4:5i]; 0 = peek only
- Ack  out  NUM_REQ  one-hot, 1-cycle pulse: transaction done
- Window  out  16  equals BitstreamShifted; valid when any Ack bit is high
- ShiftEn  out  1  shift strobe to barrel shifter (registered)
- NumShift  out  5  shift amount to barrel shifter (registered)
- Busy  out  1  state != IDLE
- ShiftErr  out  1  sticky: a request with ReqNumShift > 16 was seen
- BitCount  out  CNT_W  total bits consumed since Enable rose

Behaviour:
- Reset, or Enable low, forces the following every cycle:
  - state = IDLE;
  - Ack, ShiftEn, NumShift, Busy, ShiftErr and BitCount all 0;
  - grant register cleared;
  - round-robin pointer = 0.
- FSM states: IDLE, SHIFT, ACK.
- IDLE to SHIFT when Enable & BarrelShifterReady & |ReqValid. Otherwise stay in IDLE.
  - The winner is latched into the grant register.
  - ShiftEn is set to 1 for the next cycle, and NumShift is set to min(ReqNumShift[winner], 16).
  - If ReqNumShift[winner] > 16, ShiftErr is set (sticky until Reset or Enable low).
- A peek (amount 0) still passes through SHIFT, with ShiftEn=1 and NumShift=0. This keeps latency uniform.
- SHIFT to ACK unconditionally.
  - ShiftEn/NumShift are high/valid during exactly this cycle.
  - BitCount += NumShift. BitCount wraps modulo 2^CNT_W.
- ACK to IDLE unconditionally.
  - Ack[grant] = 1 and Window = BitstreamShifted, which the shifter has updated from the SHIFT-cycle request.
  - ShiftEn = 0.
- Latency: request sampled in IDLE at cycle t; ShiftEn at t+1; Ack at t+2; next grant can be sampled at t+3. Peak throughput is 1 transaction per 3 cycles.
- Arbitration is fixed priority: lowest index wins. See the optional feature for round-robin.
- ReqValid from the grantee during SHIFT/ACK is ignored.
- If the grantee drops ReqValid after the grant, the transaction still completes and Ack is still issued.
- A ReqValid that rises during SHIFT/ACK is considered at the next IDLE.
- BarrelShifterReady falling during SHIFT/ACK: the transaction completes. The new grant waits in IDLE.
- Enable falling mid-transaction: abort immediately, with no Ack and ShiftEn forced to 0 that cycle.
- At most one ShiftEn per 3 cycles. Never more than one Ack bit high.

Optional Feature:
- Macro: BS_SHIFT_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at rr_ptr.
  - On each grant, rr_ptr = winner+1, modulo NUM_REQ.
  - rr_ptr resets to 0.
- Undefined: fixed priority with index 0 highest. rr_ptr logic is absent.

Decomposition:
- Package bs_shift_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, ACK} bs_arb_state_t;
  - localparam MAX_SHIFT = 16;
  - localparam SHIFT_W = 5.
- Sub-module bs_req_select (combinational winner pick) is natural. It takes ReqValid and rr_ptr and produces a one-hot winner plus an index.
  - It has a fixed-priority variant and a round-robin variant, selected by the macro.

Test Plan:
- Single request, NUM_REQ=4, ReqValid=0010, amount 5 -> ShiftEn=1 with NumShift=5 at t+1, Ack=0010 at t+2, Window equals the shifter output, BitCount=5.
- Simultaneous ReqValid=1011, amount 3 each, held until each requester's Ack:
  - fixed priority -> Acks in order 0001, 0010, 1000, 3 cycles apart, BitCount=9;
  - BS_SHIFT_ARB_RR_EN defined, after prior grant to 1 -> order 1000, 0001, 0010.
- Requester 2 asks for 20 bits -> NumShift=16 and ShiftErr=1 (stays set), BitCount +16; other requesters are unaffected.
- Peek: amount 0 -> ShiftEn=1 with NumShift=0, Ack at t+2, BitCount unchanged, Window unchanged.
- BarrelShifterReady=0 with ReqValid=0001 -> no ShiftEn and Busy=0. Ready rises -> ShiftEn on the next cycle.
- Enable dropped in the SHIFT state -> next cycle IDLE, no Ack, BitCount=0, ShiftErr=0. Reset asserted mid-ACK -> all outputs 0 next cycle.
